// File: rtl/des_key_pkg.sv
// Shared constants for the DES key schedule controller: shift schedule, FSM states, widths.
// Also holds the C/D rotation helper used by the controller.
package des_key_pkg;

    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;
    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    localparam logic [1:0] SHIFT [ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {IDLE, RUN} state_t;

    // Rotate C and D halves independently by 1 or 2 positions.
    function automatic logic [2*CD_W-1:0] rot_cd(input logic [2*CD_W-1:0] cd,
                                                 input logic [1:0] n,
                                                 input logic right);
        logic [CD_W-1:0] c;
        logic [CD_W-1:0] d;
        c = cd[2*CD_W-1:CD_W];
        d = cd[CD_W-1:0];
        if (right) begin
            if (n == 2'd2) begin
                c = {c[1:0], c[CD_W-1:2]};
                d = {d[1:0], d[CD_W-1:2]};
            end else begin
                c = {c[0], c[CD_W-1:1]};
                d = {d[0], d[CD_W-1:1]};
            end
        end else begin
            if (n == 2'd2) begin
                c = {c[CD_W-3:0], c[CD_W-1:CD_W-2]};
                d = {d[CD_W-3:0], d[CD_W-1:CD_W-2]};
            end else begin
                c = {c[CD_W-2:0], c[CD_W-1]};
                d = {d[CD_W-2:0], d[CD_W-1]};
            end
        end
        return {c, d};
    endfunction

endpackage

// File: rtl/des_pc1.sv
// DES Permuted Choice 1: 64-bit key (bit 1 = MSB) to 56-bit C/D (C in the upper half).
// Parity bits 8,16,...,64 are discarded.
module des_pc1 (
    input  logic [63:0] key,
    output logic [55:0] cd
);

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign cd[55-i] = key[64-PC1_TAB[i]];
    end

    logic unused_parity_bits;
    assign unused_parity_bits = ^{key[56], key[48], key[40], key[32],
                                  key[24], key[16], key[8], key[0]};

endmodule

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: 56-bit C/D (bit 1 = MSB) to 48-bit round subkey.
module des_pc2 (
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign subkey[47-i] = cd[56-PC2_TAB[i]];
    end

    // C/D bits 9,18,22,25,35,38,43,54 never reach a subkey.
    logic unused_cd_bits;
    assign unused_cd_bits = ^{cd[47], cd[38], cd[34], cd[31],
                              cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: loads a key through PC-1, then issues the 16 PC-2 subkeys
// one per handshake, forward (encrypt) or reversed via right rotations (decrypt).
module des_key_sched_ctrl
    import des_key_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic        key_err,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        last_round
);

    state_t              state;
    logic [2*CD_W-1:0]   cd;
    logic [2*CD_W-1:0]   pc1_out;
    logic                dec_r;
    logic                parity_ok;
    logic [3:0]          idx_next;
    logic [3:0]          idx_rev;

    des_pc1 u_pc1 (.key(key_in), .cd(pc1_out));
    des_pc2 u_pc2 (.cd(cd), .subkey(subkey));

    always_comb begin
        parity_ok = 1'b1;
        if (PARITY_CHECK) begin
            for (int b = 0; b < 8; b++) begin
                if (^key_in[8*b +: 8] == 1'b0) parity_ok = 1'b0;
            end
        end
    end

    assign idx_next = round_idx + 4'd1;
    assign idx_rev  = LAST_IDX - round_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cd           <= '0;
            round_idx    <= '0;
            dec_r        <= 1'b0;
            key_ready    <= 1'b1;
            subkey_valid <= 1'b0;
            key_err      <= 1'b0;
            last_round   <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        if (parity_ok) begin
                            // Encrypt preloads the first rotation so K1 is issued next cycle.
                            cd           <= decrypt ? pc1_out : rot_cd(pc1_out, SHIFT[0], 1'b0);
                            dec_r        <= decrypt;
                            round_idx    <= '0;
                            state        <= RUN;
                            key_ready    <= 1'b0;
                            subkey_valid <= 1'b1;
                            last_round   <= 1'b0;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (subkey_ready) begin
                        if (round_idx == LAST_IDX) begin
                            round_idx    <= '0;
                            state        <= IDLE;
                            key_ready    <= 1'b1;
                            subkey_valid <= 1'b0;
                            last_round   <= 1'b0;
                        end else begin
                            cd         <= dec_r ? rot_cd(cd, SHIFT[idx_rev], 1'b1)
                                                : rot_cd(cd, SHIFT[idx_next], 1'b0);
                            round_idx  <= idx_next;
                            last_round <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: a cumulative-shift key schedule model checked every cycle,
// plus directed scenarios with literal subkeys.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        key_err;
    logic        subkey_valid;
    logic        subkey_ready = 1'b0;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        last_round;

    des_key_sched_ctrl #(.PARITY_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .decrypt(decrypt), .key_err(key_err),
        .subkey_valid(subkey_valid), .subkey_ready(subkey_ready), .subkey(subkey),
        .round_idx(round_idx), .last_round(last_round)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY2 = 64'h0123456789ABCDEF;
    localparam logic [63:0] BAD  = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

    int SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
    int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit odd_parity(input logic [63:0] k);
        for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) return 1'b0;
        return 1'b1;
    endfunction

    // Subkey issued at position i: key number K(i+1) or K(16-i), from its cumulative shift.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input logic dec,
                                               input logic [3:0] i);
        int kn;
        int cum;
        logic [55:0] p;
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cdv;
        logic [47:0] r;
        kn = dec ? 16 - int'(i) : int'(i) + 1;
        cum = 0;
        for (int j = 0; j < kn; j++) cum += SH[j];
        for (int b = 0; b < 56; b++) p[55-b] = k[64-PC1[b]];
        c = p[55:28];
        d = p[27:0];
        for (int s = 0; s < cum; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cdv = {c, d};
        for (int b = 0; b < 48; b++) r[47-b] = cdv[56-PC2[b]];
        return r;
    endfunction

    // Transaction-level model of the controller.
    logic        m_busy = 1'b0;
    logic [3:0]  m_idx  = '0;
    logic        m_err  = 1'b0;
    logic [63:0] m_key  = '0;
    logic        m_dec  = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_idx  <= '0;
            m_err  <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (!m_busy) begin
                if (key_valid) begin
                    if (odd_parity(key_in)) begin
                        m_busy <= 1'b1;
                        m_idx  <= '0;
                        m_key  <= key_in;
                        m_dec  <= decrypt;
                    end else begin
                        m_err <= 1'b1;
                    end
                end
            end else if (subkey_ready) begin
                if (m_idx == 4'd15) begin
                    m_busy <= 1'b0;
                    m_idx  <= '0;
                end else begin
                    m_idx <= m_idx + 4'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_key_ready", key_ready, !m_busy);
            check("mdl_subkey_valid", subkey_valid, m_busy);
            check("mdl_round_idx", round_idx, m_idx);
            check("mdl_last_round", last_round, m_busy && (m_idx == 4'd15));
            check("mdl_key_err", key_err, m_err);
            if (m_busy) check("mdl_subkey", subkey, ref_subkey(m_key, m_dec, m_idx));
        end
    end

    logic [47:0] got [$];
    logic [47:0] enc_seq [$];

    task automatic load_key(input logic [63:0] k, input logic dec);
        key_in    = k;
        decrypt   = dec;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        decrypt   = ~dec;
    endtask

    task automatic run_sched(input bit stall, input string tag);
        int hs = 0;
        int cyc = 0;
        bit prev_stalled = 1'b0;
        logic [47:0] prev_sk = '0;
        logic [3:0]  prev_idx = '0;
        got.delete();
        while (hs < 16 && cyc < 400) begin
            if (prev_stalled) begin
                check({tag, "_hold_subkey"}, subkey, prev_sk);
                check({tag, "_hold_idx"}, round_idx, prev_idx);
            end
            subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (subkey_valid && subkey_ready) begin
                got.push_back(subkey);
                check({tag, "_idx"}, round_idx, 64'(hs));
                check({tag, "_last"}, last_round, hs == 15);
                hs++;
                prev_stalled = 1'b0;
            end else begin
                prev_stalled = subkey_valid;
                prev_sk      = subkey;
                prev_idx     = round_idx;
            end
            @(negedge clk);
            cyc++;
        end
        subkey_ready = 1'b0;
        check({tag, "_handshakes"}, 64'(hs), 64'd16);
        check({tag, "_key_ready_after"}, key_ready, 1'b1);
        check({tag, "_valid_after"}, subkey_valid, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_key_ready", key_ready, 1'b1);
        check("rst_subkey_valid", subkey_valid, 1'b0);
        check("rst_round_idx", round_idx, 4'd0);
        check("rst_key_err", key_err, 1'b0);
        check("rst_last_round", last_round, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        check("model_k1", ref_subkey(KEY, 1'b0, 4'd0), K1);
        check("model_k16", ref_subkey(KEY, 1'b0, 4'd15), K16);
        check("model_dec_first", ref_subkey(KEY, 1'b1, 4'd0), K16);

        // Plain encrypt, no backpressure
        load_key(KEY, 1'b0);
        run_sched(1'b0, "enc");
        check("enc_first", got[0], K1);
        check("enc_last", got[15], K16);
        enc_seq = got;

        // Decrypt must be the exact reverse
        load_key(KEY, 1'b1);
        run_sched(1'b0, "dec");
        check("dec_first", got[0], K16);
        check("dec_last", got[15], K1);
        for (int i = 0; i < 16; i++) check("dec_reverse", got[i], enc_seq[15-i]);

        // Random backpressure
        load_key(KEY, 1'b0);
        run_sched(1'b1, "stall");
        for (int i = 0; i < 16; i++) check("stall_seq", got[i], enc_seq[i]);

        // Second key held on key_valid during RUN
        load_key(KEY, 1'b0);
        key_in    = KEY2;
        decrypt   = 1'b1;
        key_valid = 1'b1;
        run_sched(1'b0, "hold");
        for (int i = 0; i < 16; i++) check("hold_seq", got[i], enc_seq[i]);
        @(negedge clk);
        key_valid = 1'b0;
        decrypt   = 1'b0;
        check("key2_accepted", subkey_valid, 1'b1);
        run_sched(1'b0, "key2");
        for (int i = 0; i < 16; i++) check("key2_seq", got[i], ref_subkey(KEY2, 1'b1, 4'(i)));

        // Parity failure
        key_in    = BAD;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("perr_key_err", key_err, 1'b1);
        check("perr_valid", subkey_valid, 1'b0);
        check("perr_key_ready", key_ready, 1'b1);
        @(negedge clk);
        check("perr_pulse_end", key_err, 1'b0);
        check("perr_valid2", subkey_valid, 1'b0);
        load_key(KEY, 1'b0);
        run_sched(1'b0, "after_err");
        check("after_err_first", got[0], K1);

        // Reset in the middle of a schedule
        load_key(KEY, 1'b0);
        subkey_ready = 1'b1;
        begin
            int n = 0;
            while (round_idx != 4'd7 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_mid_reached", round_idx, 4'd7);
        rst = 1'b1;
        subkey_ready = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", subkey_valid, 1'b0);
        check("rst_mid_key_ready", key_ready, 1'b1);
        check("rst_mid_idx", round_idx, 4'd0);
        check("rst_mid_last", last_round, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_no_resume", subkey_valid, 1'b0);
        load_key(KEY, 1'b0);
        run_sched(1'b0, "post_rst");
        check("post_rst_first", got[0], K1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
